gmii_read: RTL

- Drain side of the per-port RX byte FIFO; sits directly downstream of the GMII-write stage.
- Reads 9-bit FIFO words, where bit 8 is a boundary flag:
  - first flagged word of a frame = head;
  - next flagged word = tail;
  - a single flagged word is head and tail together (runt or overflow marker).
- Strips preamble/SFD, checks length, and emits a byte stream with sop/eop/err to the packet-packing stage.
- Downstream always accepts; there is no backpressure.

---
 rtl/gmii_read_pkg.sv | 26 ++
 rtl/gmii_read_stat.sv | 33 +++
 rtl/gmii_read.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/gmii_read_pkg.sv
// Shared definitions for the GMII RX FIFO drain stage (gmii_read).
// State encodings, framing byte constants and default length limits.
package gmii_read_pkg;

  typedef enum logic [1:0] {
    IDLE_S    = 2'b00,
    PREAM_S   = 2'b01,
    TRANS_S   = 2'b10,
    DISCARD_S = 2'b11
  } state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int MIN_LEN_DEF = 64;
  localparam int MAX_LEN_DEF = 1522;

  // One emitted byte plus its framing qualifiers.
  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       err;
  } out_byte_t;

endpackage

// File: rtl/gmii_read_stat.sv
// Saturating frame statistics for gmii_read (built only with GMII_READ_STAT_EN).
// Counters sample the registered frame-end pulses of the parent.
module gmii_read_stat (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        good_i,
  input  logic        bad_i,
  input  logic        trunc_i,
  output logic [31:0] good_cnt_o,
  output logic [31:0] bad_cnt_o,
  output logic [15:0] trunc_cnt_o
);

  logic [31:0] good_cnt_q, bad_cnt_q;
  logic [15:0] trunc_cnt_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      trunc_cnt_q <= '0;
    end else begin
      if (good_i  && (good_cnt_q  != '1)) good_cnt_q  <= good_cnt_q  + 32'd1;
      if (bad_i   && (bad_cnt_q   != '1)) bad_cnt_q   <= bad_cnt_q   + 32'd1;
      if (trunc_i && (trunc_cnt_q != '1)) trunc_cnt_q <= trunc_cnt_q + 16'd1;
    end
  end

  assign good_cnt_o  = good_cnt_q;
  assign bad_cnt_o   = bad_cnt_q;
  assign trunc_cnt_o = trunc_cnt_q;

endmodule

// File: rtl/gmii_read.sv
// Drains the per-port RX byte FIFO: strips preamble/SFD, checks length, emits sop/eop/err bytes.
// Optional saturating statistics outputs are enabled with the GMII_READ_STAT_EN macro.
module gmii_read
  import gmii_read_pkg::*;
#(
  parameter int MIN_LEN   = MIN_LEN_DEF,
  parameter int MAX_LEN   = MAX_LEN_DEF,
  parameter int PREAM_MAX = 7,
  parameter int LEN_W     = 11
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [8:0]  iv_data,
  input  logic        i_data_empty,
  output logic        o_data_rd,
  output logic [7:0]  ov_byte,
  output logic        o_byte_wr,
  output logic        o_sop,
  output logic        o_eop,
  output logic        o_err,
  output logic        o_bad_pulse
`ifdef GMII_READ_STAT_EN
  ,
  output logic [31:0] ov_good_cnt,
  output logic [31:0] ov_bad_cnt,
  output logic [15:0] ov_trunc_cnt
`endif
);

  localparam logic [LEN_W:0]   MIN_LC     = (LEN_W+1)'(MIN_LEN);
  localparam logic [LEN_W:0]   MAX_LC     = (LEN_W+1)'(MAX_LEN);
  localparam logic [2:0]       PREAM_MAXC = 3'(PREAM_MAX);

  state_e           state_q;
  logic             rd_q, rd_vld_q;
  logic [2:0]       pream_cnt_q;
  logic [LEN_W-1:0] len_cnt_q;
  logic             sop_pend_q;
  out_byte_t        out_q;
  logic             byte_wr_q, bad_q;
`ifdef GMII_READ_STAT_EN
  logic             trunc_q;
`endif

  logic             flag;
  logic [7:0]       data;
  logic [LEN_W:0]   len_nxt_d;
  logic [LEN_W-1:0] len_sat_d;
  logic             runt_d, at_max_d;

  assign flag      = iv_data[8];
  assign data      = iv_data[7:0];
  // Length including the current byte; one extra bit so the compare never wraps.
  assign len_nxt_d = {1'b0, len_cnt_q} + {{LEN_W{1'b0}}, 1'b1};
  assign len_sat_d = (len_nxt_d > MAX_LC) ? MAX_LC[LEN_W-1:0] : len_nxt_d[LEN_W-1:0];
  assign runt_d    = (len_nxt_d < MIN_LC);
  assign at_max_d  = (len_nxt_d == MAX_LC);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE_S;
      rd_q        <= 1'b0;
      rd_vld_q    <= 1'b0;
      pream_cnt_q <= '0;
      len_cnt_q   <= '0;
      sop_pend_q  <= 1'b0;
      out_q       <= '0;
      byte_wr_q   <= 1'b0;
      bad_q       <= 1'b0;
`ifdef GMII_READ_STAT_EN
      trunc_q     <= 1'b0;
`endif
    end else begin
      rd_q      <= !i_data_empty;
      rd_vld_q  <= rd_q;
      byte_wr_q <= 1'b0;
      out_q.sop <= 1'b0;
      out_q.eop <= 1'b0;
      out_q.err <= 1'b0;
      bad_q     <= 1'b0;
`ifdef GMII_READ_STAT_EN
      trunc_q   <= 1'b0;
`endif
      if (rd_vld_q) begin
        case (state_q)
          IDLE_S: begin
            // Lone flagged non-preamble word is an overflow/runt marker or a stray tail.
            if (flag) begin
              if (data == PREAMBLE_BYTE) begin
                state_q     <= PREAM_S;
                pream_cnt_q <= 3'd1;
              end else begin
                bad_q <= 1'b1;
              end
            end
          end
          PREAM_S: begin
            if (flag) begin
              bad_q   <= 1'b1;
              state_q <= IDLE_S;
            end else if (data == SFD_BYTE) begin
              state_q    <= TRANS_S;
              len_cnt_q  <= '0;
              sop_pend_q <= 1'b1;
            end else if ((data == PREAMBLE_BYTE) && (pream_cnt_q < PREAM_MAXC)) begin
              pream_cnt_q <= pream_cnt_q + 3'd1;
            end else begin
              bad_q   <= 1'b1;
              state_q <= DISCARD_S;
            end
          end
          TRANS_S: begin
            out_q.data <= data;
            out_q.sop  <= sop_pend_q;
            byte_wr_q  <= 1'b1;
            sop_pend_q <= 1'b0;
            len_cnt_q  <= len_sat_d;
            // Tail is checked first so a tail landing exactly on MAX_LEN ends cleanly.
            if (flag) begin
              out_q.eop <= 1'b1;
              out_q.err <= runt_d;
              bad_q     <= runt_d;
              state_q   <= IDLE_S;
            end else if (at_max_d) begin
              out_q.eop <= 1'b1;
              out_q.err <= 1'b1;
              bad_q     <= 1'b1;
              state_q   <= DISCARD_S;
`ifdef GMII_READ_STAT_EN
              trunc_q   <= 1'b1;
`endif
            end
          end
          DISCARD_S: begin
            if (flag) state_q <= IDLE_S;
          end
          default: state_q <= IDLE_S;
        endcase
      end
    end
  end

  assign o_data_rd   = rd_q;
  assign ov_byte     = out_q.data;
  assign o_byte_wr   = byte_wr_q;
  assign o_sop       = out_q.sop;
  assign o_eop       = out_q.eop;
  assign o_err       = out_q.err;
  assign o_bad_pulse = bad_q;

`ifdef GMII_READ_STAT_EN
  gmii_read_stat u_stat (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .good_i      (out_q.eop & ~out_q.err),
    .bad_i       (bad_q),
    .trunc_i     (trunc_q),
    .good_cnt_o  (ov_good_cnt),
    .bad_cnt_o   (ov_bad_cnt),
    .trunc_cnt_o (ov_trunc_cnt)
  );
`endif

endmodule
